// File: rtl/par_serial_pkg.sv
// Shared constants, state encoding and LFSR step helper for the byte-to-bit serializer.
// The optional scrambler (PAR_SERIAL_SCRAMBLE_EN) uses the LFSR definitions here.
package par_serial_pkg;

  localparam logic [7:0]  COM_SYM   = 8'hBC;
  localparam logic [15:0] LFSR_SEED = 16'hFFFF;
  // x^16+x^5+x^4+x^3+1 in Galois form: feedback into bits 5,4,3,0
  localparam logic [15:0] LFSR_TAPS = 16'h0039;

  typedef enum logic {
    TRAIN  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], 1'b0} ^ (s[15] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/pcie_scrambler8.sv
// PCIe Gen1 scrambler producing one 8-bit XOR mask per data symbol.
// Only instantiated when PAR_SERIAL_SCRAMBLE_EN is defined.
module pcie_scrambler8
  import par_serial_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       seed_i,
  input  logic       advance_i,
  output logic [7:0] mask
);

  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  // Mask bit 7 is the first bit on the wire, so it takes the first LFSR output.
  always_comb begin
    lfsr_next = lfsr;
    mask      = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mask[7-i] = lfsr_next[15];
      lfsr_next = lfsr_step(lfsr_next);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || seed_i) begin
      lfsr <= LFSR_SEED;
    end else if (advance_i) begin
      lfsr <= lfsr_next;
    end
  end

endmodule

// File: rtl/par_serial_tx.sv
// Byte-to-bit serializer: MSB-first shift-out, COM training burst after reset, COM fill when idle.
// Define PAR_SERIAL_SCRAMBLE_EN to XOR data bytes with the PCIe Gen1 scrambler mask.
module par_serial_tx
  import par_serial_pkg::*;
#(
  parameter int SYNC_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       sym_start,
  output logic       active_out
);

  localparam int CNT_W = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;

  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [CNT_W-1:0] sym_cnt;
  state_t           state;
  logic             load;
  logic             take_data;
  logic [7:0]       payload;
  logic [7:0]       sel;

  assign load      = (bit_cnt == 3'd7);
  assign take_data = (state == ACTIVE) && valid_in;

`ifdef PAR_SERIAL_SCRAMBLE_EN
  logic [7:0] scr_mask;

  // Every COM load reseeds the LFSR; only data loads advance it.
  pcie_scrambler8 u_scrambler (
    .clk       (clk),
    .reset     (reset),
    .seed_i    (load && !take_data),
    .advance_i (load && take_data),
    .mask      (scr_mask)
  );

  assign payload = data_in ^ scr_mask;
`else
  assign payload = data_in;
`endif

  assign sel       = take_data ? payload : COM_SYM;
  assign ready_out = load && (state == ACTIVE) && !reset;
  assign data_out  = shreg[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= 3'd7;
      shreg      <= 8'h00;
      sym_cnt    <= '0;
      state      <= TRAIN;
      sym_start  <= 1'b0;
      active_out <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt + 3'd1;
      sym_start <= load;
      if (load) begin
        shreg <= sel;
      end else begin
        shreg <= {shreg[6:0], 1'b0};
      end
      // Training counts COM loads; the last one flips the FSM on the same edge.
      if (load && (state == TRAIN)) begin
        sym_cnt <= sym_cnt + CNT_W'(1);
        if (sym_cnt == CNT_W'(SYNC_COUNT - 1)) begin
          state      <= ACTIVE;
          active_out <= 1'b1;
        end
      end
    end
  end

endmodule
